// File: rtl/state_mon_pkg.sv
// Shared types and default constants for the FSM-state target monitor.
package state_mon_pkg;

  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE  = 2'd0;
  localparam mon_state_t ST_ARMED = 2'd1;
  localparam mon_state_t ST_TRACK = 2'd2;
  localparam mon_state_t ST_DONE  = 2'd3;

  localparam int         DEF_STATE_W = 2;
  localparam logic [1:0] DEF_TARGET  = 2'b10;
  localparam int         DEF_CNT_W   = 8;
  localparam int         DEF_WINDOW  = 20;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     q <= '0;
    else if (clr)                     q <= '0;
    else if (inc && (q != {W{1'b1}})) q <= q + W'(1);
  end

endmodule

// File: rtl/state_target_monitor.sv
// Observes a sampled FSM state, counts entries into TARGET over a bounded window and
// reports first-hit latency, hit count and timeout as registered results.
module state_target_monitor
  import state_mon_pkg::*;
#(
  parameter int                 STATE_W = DEF_STATE_W,
  parameter logic [STATE_W-1:0] TARGET  = STATE_W'(DEF_TARGET),
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter int                 WINDOW  = DEF_WINDOW
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sample_en,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               hit,
  output logic               reached,
  output logic [CNT_W-1:0]   first_latency,
  output logic [CNT_W-1:0]   hit_count,
  output logic               timeout,
  output logic               done
);

  // Sample index is sized from WINDOW, so a narrow CNT_W still sees a full window.
  localparam int CYC_W = $clog2(WINDOW + 1);
  localparam int XW    = (CYC_W > CNT_W) ? CYC_W : CNT_W;

  mon_state_t       st;
  logic [CYC_W-1:0] cyc;
  logic             in_tgt_q;
  logic             smp, is_tgt, hit_now, win_end;
  logic [XW-1:0]    cyc_x, lat_max;
  logic [CNT_W-1:0] cyc_lat;

  assign busy    = (st == ST_ARMED) || (st == ST_TRACK);
  assign smp     = busy & sample_en & ~start;
  assign is_tgt  = (state_in == TARGET);
  assign hit_now = smp & is_tgt & ~in_tgt_q;
  assign win_end = smp & (cyc == CYC_W'(WINDOW - 1));

  // Latency saturates like the other counters when the window outgrows CNT_W.
  assign cyc_x   = XW'(cyc);
  assign lat_max = XW'({CNT_W{1'b1}});
  assign cyc_lat = (cyc_x > lat_max) ? {CNT_W{1'b1}} : CNT_W'(cyc_x);

  sat_counter #(.W(CYC_W)) u_cyc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (smp),
    .q       (cyc)
  );

  sat_counter #(.W(CNT_W)) u_hits (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (start),
    .inc     (hit_now),
    .q       (hit_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= ST_IDLE;
      in_tgt_q      <= 1'b0;
      hit           <= 1'b0;
      reached       <= 1'b0;
      first_latency <= '0;
      timeout       <= 1'b0;
      done          <= 1'b0;
    end else begin
      hit <= hit_now;
      if (start) begin
        st            <= ST_ARMED;
        in_tgt_q      <= 1'b0;
        reached       <= 1'b0;
        first_latency <= '0;
        timeout       <= 1'b0;
        done          <= 1'b0;
      end else if (smp) begin
        in_tgt_q <= is_tgt;
        if (hit_now) begin
          reached <= 1'b1;
          if (!reached) first_latency <= cyc_lat;
        end
        // The closing sample is fully processed, so its hit clears timeout.
        if (win_end) begin
          st      <= ST_DONE;
          done    <= 1'b1;
          timeout <= ~(reached | hit_now);
        end else if ((st == ST_ARMED) && hit_now) begin
          st <= ST_TRACK;
        end
      end
    end
  end

endmodule

// File: tb/tb_state_target_monitor.sv
// Randomized and directed checks of state_target_monitor against a sample-level model.
module tb_state_target_monitor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sample_en = 1'b0;
  logic [1:0] state_in = 2'b00;

  logic       busy_a, hit_a, reached_a, timeout_a, done_a;
  logic [7:0] first_a, count_a;
  logic       busy_b, hit_b, reached_b, timeout_b, done_b;
  logic [2:0] first_b, count_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one record per run, updated once per clock.
  bit m_busy, m_hit, m_reached, m_done, m_timeout, m_prev;
  int m_first, m_count, m_cyc;

  always #5 clock = ~clock;

  state_target_monitor #(.CNT_W(8), .WINDOW(20)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .sample_en(sample_en),
    .state_in(state_in), .busy(busy_a), .hit(hit_a), .reached(reached_a),
    .first_latency(first_a), .hit_count(count_a), .timeout(timeout_a), .done(done_a)
  );

  state_target_monitor #(.CNT_W(3), .WINDOW(20)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .sample_en(sample_en),
    .state_in(state_in), .busy(busy_b), .hit(hit_b), .reached(reached_b),
    .first_latency(first_b), .hit_count(count_b), .timeout(timeout_b), .done(done_b)
  );

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_hit = 0; m_reached = 0; m_done = 0; m_timeout = 0; m_prev = 0;
    m_first = 0; m_count = 0; m_cyc = 0;
  endtask

  // Drive one cycle, let the edge happen, advance the model, settle 1ns past the edge.
  task automatic step(input bit s, input bit e, input logic [1:0] st);
    bit h;
    start = s; sample_en = e; state_in = st;
    @(posedge clock);
    if (s) begin
      model_clear();
      m_busy = 1;
    end else if (m_busy && e) begin
      h = (st == 2'b10) && !m_prev;
      m_prev = (st == 2'b10);
      m_hit = h;
      if (h) begin
        m_count++;
        if (!m_reached) m_first = m_cyc;
        m_reached = 1;
      end
      if (m_cyc == 19) begin
        m_busy = 0; m_done = 1; m_timeout = !m_reached;
      end
      m_cyc++;
    end else begin
      m_hit = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy_a, hit_a, reached_a, first_a, count_a, timeout_a, done_a} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b hit=%b reached=%b lat=%0d cnt=%0d to=%b done=%b, want all 0",
               busy_a, hit_a, reached_a, first_a, count_a, timeout_a, done_a);
    end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_first_hit();
    step(1, 0, 2'b00);
    step(0, 1, 2'b00);
    step(0, 1, 2'b01);
    step(0, 1, 2'b11);
    vectors++;
    if (hit_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL first_hit_pre got hit=%b busy=%b want hit=0 busy=1", hit_a, busy_a);
    end
    step(0, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b1 || first_a !== 8'd3 || count_a !== 8'd1 || reached_a !== 1'b1) begin
      miscompares++;
      $display("FAIL first_hit got hit=%b lat=%0d cnt=%0d reached=%b want 1/3/1/1",
               hit_a, first_a, count_a, reached_a);
    end
    step(0, 0, 2'b10);
    vectors++;
    if (hit_a !== 1'b0) begin
      miscompares++;
      $display("FAIL first_hit_pulse got hit=%b want 0", hit_a);
    end
  endtask

  task automatic test_hold_reentry();
    int pulses = 0;
    step(1, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'b10);
      pulses += hit_a;
    end
    step(0, 1, 2'b00);
    pulses += hit_a;
    step(0, 1, 2'b10);
    pulses += hit_a;
    vectors++;
    if (pulses != 2 || count_a !== 8'd2 || first_a !== 8'd0) begin
      miscompares++;
      $display("FAIL hold_reentry got pulses=%0d cnt=%0d lat=%0d want 2/2/0", pulses, count_a, first_a);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] miss;
    step(1, 0, 2'b00);
    for (int i = 0; i < 19; i++) begin
      miss = 2'($urandom_range(0, 2));
      if (miss == 2'b10) miss = 2'b11;
      step(0, 1, miss);
    end
    vectors++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pre got busy=%b done=%b want 1/0", busy_a, done_a);
    end
    step(0, 1, 2'b01);
    vectors++;
    if (done_a !== 1'b1 || timeout_a !== 1'b1 || reached_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout got done=%b to=%b reached=%b busy=%b want 1/1/0/0",
               done_a, timeout_a, reached_a, busy_a);
    end
    step(0, 1, 2'b10);
    vectors++;
    if (done_a !== 1'b1 || hit_a !== 1'b0 || count_a !== 8'd0) begin
      miscompares++;
      $display("FAIL done_hold got done=%b hit=%b cnt=%0d want 1/0/0", done_a, hit_a, count_a);
    end
  endtask

  task automatic test_window_edges();
    step(1, 0, 2'b00);
    step(0, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b1 || first_a !== 8'd0) begin
      miscompares++;
      $display("FAIL first_sample_hit got hit=%b lat=%0d want 1/0", hit_a, first_a);
    end
    step(1, 0, 2'b00);
    for (int i = 0; i < 19; i++) step(0, 1, 2'b00);
    step(0, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b1 || done_a !== 1'b1 || timeout_a !== 1'b0 || first_a !== 8'd19) begin
      miscompares++;
      $display("FAIL last_sample_hit got hit=%b done=%b to=%b lat=%0d want 1/1/0/19",
               hit_a, done_a, timeout_a, first_a);
    end
    vectors++;
    if (first_b !== 3'd7) begin
      miscompares++;
      $display("FAIL latency_sat got %0d want 7", first_b);
    end
  endtask

  task automatic test_gaps_and_start();
    step(1, 0, 2'b00);
    step(0, 1, 2'b00);
    step(0, 0, 2'b10);
    step(0, 1, 2'b01);
    step(0, 0, 2'b10);
    step(0, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b1 || first_a !== 8'd2) begin
      miscompares++;
      $display("FAIL gap_latency got hit=%b lat=%0d want 1/2", hit_a, first_a);
    end
    step(1, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b0 || count_a !== 8'd0 || reached_a !== 1'b0 || busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL start_collision got hit=%b cnt=%0d reached=%b busy=%b want 0/0/0/1",
               hit_a, count_a, reached_a, busy_a);
    end
    step(0, 1, 2'b10);
    vectors++;
    if (hit_a !== 1'b1 || first_a !== 8'd0) begin
      miscompares++;
      $display("FAIL post_start_sample got hit=%b lat=%0d want 1/0", hit_a, first_a);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 2'b00);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 2'b10);
      step(0, 1, 2'b00);
    end
    vectors++;
    if (count_b !== 3'd7 || count_a !== 8'd9 || busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL count_sat got cnt_b=%0d cnt_a=%0d busy_b=%b want 7/9/1", count_b, count_a, busy_b);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 2'b00);
    step(0, 1, 2'b10);
    step(0, 1, 2'b00);
    step(0, 1, 2'b10);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy_a, hit_a, reached_a, first_a, count_a, timeout_a, done_a} !== 21'd0 ||
        {busy_b, reached_b, count_b} !== 5'd0) begin
      miscompares++;
      $display("FAIL async_reset got busy=%b hit=%b reached=%b cnt=%0d cnt_b=%0d want all 0",
               busy_a, hit_a, reached_a, count_a, count_b);
    end
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    bit s, e;
    logic [1:0] st;
    step(1, 0, 2'b00);
    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      st = $urandom_range(0, 1) ? 2'b10 : 2'($urandom_range(0, 3));
      step(s, e, st);
      vectors++;
      if (busy_a !== m_busy || hit_a !== m_hit || reached_a !== m_reached ||
          done_a !== m_done || timeout_a !== m_timeout) begin
        miscompares++;
        $display("FAIL rand_flags i=%0d got b%b h%b r%b d%b t%b want b%b h%b r%b d%b t%b", i,
                 busy_a, hit_a, reached_a, done_a, timeout_a,
                 m_busy, m_hit, m_reached, m_done, m_timeout);
      end
      vectors++;
      if (first_a !== 8'(sat(m_first, 8)) || count_a !== 8'(sat(m_count, 8))) begin
        miscompares++;
        $display("FAIL rand_counts i=%0d got lat=%0d cnt=%0d want %0d/%0d", i,
                 first_a, count_a, sat(m_first, 8), sat(m_count, 8));
      end
      vectors++;
      if (first_b !== 3'(sat(m_first, 3)) || count_b !== 3'(sat(m_count, 3)) ||
          hit_b !== m_hit || done_b !== m_done || timeout_b !== m_timeout) begin
        miscompares++;
        $display("FAIL rand_narrow i=%0d got lat=%0d cnt=%0d h%b d%b t%b want %0d/%0d", i,
                 first_b, count_b, hit_b, done_b, timeout_b, sat(m_first, 3), sat(m_count, 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_hold_reentry();
    test_timeout();
    test_window_edges();
    test_gaps_and_start();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
